me_search_ctrl: RTL and testbench
=================================

Name: me_search_ctrl

Overview:
- Sequencer upstream of the motion-estimation comparator and the 16-PE SAD array.
- Sweeps a 16x16 reference block over 16x16 candidate displacements, dx,dy in -8..+7.
- Drives the comparator inputs: CompStart, one-hot PEready and the candidate vector X/Y.
- Also drives per-PE accumulator-clear strobes, the reference/search memory addresses and the S1/S2 column mux selects.

Parameters:
- NUM_PE, 16, number of processing elements; only 16 supported.
- VEC_W, 8, width of o_vectorX/o_vectorY (signed two's complement).
- BLK_PIX, 256, pixels per reference block = cycles per row pass (localparam, not overridable).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  start a full search; sampled in IDLE and HOLD only.
- o_busy  out  1  high in RUN and DONE.
- o_done  out  1  one-cycle pulse when the search completes.
- o_CompStart  out  1  comparator enable; low re-initialises the best distance.
- o_PEready  out  16  one-hot; PE i's distance is final this cycle.
- o_NewDist  out  16  one-hot; PE i clears its accumulator and starts a new pass.
- o_S1S2mux  out  16  per-PE select; 1 = take the pixel from search memory S2.
- o_AddressR  out  8  reference memory address.
- o_AddressS  out  9  search memory address {row[4:0], col[3:0]}.
- o_vectorX  out  VEC_W  candidate dx for the PE flagged in o_PEready.
- o_vectorY  out  VEC_W  candidate dy for the PE flagged in o_PEready.

Behaviour:
Reset and state:
- Reset (i_rst_n=0 at edge, any state, including mid-search): state=IDLE, c=0, all outputs 0.
- Internal 13-bit cycle counter c; LAST=4111.
- Every output is a combinational decode of registered state and c; no extra latency. The comparator samples the outputs in the same cycle.

FSM:
- IDLE: i_start=1 -> RUN with c=0.
- RUN: c increments by 1 each cycle; at c=LAST -> DONE. i_start is ignored.
- DONE: lasts one cycle, o_done=1 -> HOLD.
- HOLD: all strobes 0; comparator results stay valid. i_start=1 -> RUN with c=0.

Output decode:
- o_busy = (RUN or DONE).
- o_CompStart = (RUN and c!=0) or DONE or HOLD. The c=0 cycle of every run is low, which resets the comparator.
- o_NewDist = 1<<c[3:0] when RUN, c<4096 and c[7:4]==0; else 0. PE i starts pass r at c = r*256 + i.
- o_PEready = 1<<c[3:0] when RUN, c>=256 and c[7:4]==0; else 0. PE i finishes pass r at c = r*256 + i + 256.
- Vectors, when o_PEready != 0:
  - r = c[12:8] - 1.
  - o_vectorX = c[3:0] - 8.
  - o_vectorY = r - 8.
  - Both sign-extended to VEC_W; 0 when o_PEready == 0.
- Addresses, for RUN and c<4096 (else 0):
  - r = c[12:8].
  - o_AddressR = c[7:0].
  - o_AddressS row = r + c[7:4] (0..30, 5 bits).
  - o_AddressS col = c[3:0].
- o_S1S2mux bit i = (c[3:0] < i) when RUN and c<4096; else 0.

Boundaries and summary:
- At c=4096..4111 only o_PEready/vectors are active: final pass tails, PEs 0..15.
- Total: 4112 RUN cycles + 1 DONE cycle from the i_start edge.
- Exactly 256 PEready pulses per search, one per (dx,dy).

Optional Feature:
ME_SEARCH_CTRL_ABORT_EN:
- Defined: adds input i_abort (1 bit).
- i_abort=1 in RUN or DONE -> IDLE next cycle, c=0, no o_done pulse, all strobes 0 from the next cycle.
- i_abort has priority over i_start; it is ignored in IDLE and HOLD.
- Undefined: no port; a search always runs to completion.

Decomposition:
- Shared package me_pkg holds:
  - NUM_PE, BLK_PIX, LAST_CNT=4111, VEC_W.
  - State enum {IDLE, RUN, DONE, HOLD}.
  - Distance width DIST_W=8, shared with the comparator.
- Sub-module: none required. The FSM, counter and decode fit in one module; an optional pure-combinational me_onehot16 decoder may be split out.

Test Plan:
- Reset mid-RUN at c=1000 -> next cycle IDLE, all outputs 0, no o_done; a subsequent i_start runs the full 4112 cycles.
- i_start pulse from IDLE, check these cycles of RUN:
  - c=0: CompStart=0, NewDist=0x0001.
  - c=1: CompStart=1.
  - c=256: PEready=0x0001, vectorX=0xF8, vectorY=0xF8.
  - c=271: PEready=0x8000, X=0x07, Y=0xF8.
  - c=272: PEready=0.
- End of search:
  - c=3855: NewDist=0x8000.
  - c=4111: PEready=0x8000, X=0x07, Y=0x07.
  - Next cycle: o_done=1 for exactly one cycle, then HOLD with CompStart=1, busy=0.
- Address/mux decode:
  - c=300: AddressR=44, AddressS=9'd60 (row 3, col 12).
  - c=3: S1S2mux=0xFFF0.
  - c=4100: AddressR=0, AddressS=0, S1S2mux=0.
- i_start held high throughout -> ignored in RUN; after HOLD a new run restarts at c=0 with CompStart low for one cycle. Scoreboard counts 256 PEready pulses covering all 256 (dx,dy) pairs exactly once.
- With ME_SEARCH_CTRL_ABORT_EN: i_abort at c=500 with i_start=1 -> IDLE next cycle, no o_done. Without the macro the port is absent and the run completes.

Source files
------------

// File: rtl/me_search_ctrl_pkg.sv
// Shared constants and types for the motion-estimation search sequencer
// and its comparator / SAD array neighbours.
package me_pkg;

  localparam int NUM_PE   = 16;
  localparam int BLK_PIX  = 256;
  localparam int LAST_CNT = 4111;
  localparam int VEC_W    = 8;
  localparam int DIST_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } me_state_e;

endpackage

// File: rtl/me_search_ctrl_if.sv
// Sequencer-to-datapath bundle; optional i_abort when ME_SEARCH_CTRL_ABORT_EN
// is defined.
interface me_search_ctrl_if;
  import me_pkg::*;

  logic             i_start;
`ifdef ME_SEARCH_CTRL_ABORT_EN
  logic             i_abort;
`endif
  logic             o_busy;
  logic             o_done;
  logic             o_CompStart;
  logic [15:0]      o_PEready;
  logic [15:0]      o_NewDist;
  logic [15:0]      o_S1S2mux;
  logic [7:0]       o_AddressR;
  logic [8:0]       o_AddressS;
  logic [VEC_W-1:0] o_vectorX;
  logic [VEC_W-1:0] o_vectorY;

  modport master (
    input  i_start,
`ifdef ME_SEARCH_CTRL_ABORT_EN
    input  i_abort,
`endif
    output o_busy, o_done, o_CompStart,
    output o_PEready, o_NewDist, o_S1S2mux,
    output o_AddressR, o_AddressS,
    output o_vectorX, o_vectorY
  );

  modport slave (
    output i_start,
`ifdef ME_SEARCH_CTRL_ABORT_EN
    output i_abort,
`endif
    input  o_busy, o_done, o_CompStart,
    input  o_PEready, o_NewDist, o_S1S2mux,
    input  o_AddressR, o_AddressS,
    input  o_vectorX, o_vectorY
  );

endinterface

// File: rtl/me_search_ctrl_onehot16.sv
// 4-to-16 one-hot decoder used for the per-PE strobes.
module me_onehot16 (
  input  logic [3:0]  sel_i,
  output logic [15:0] oh_o
);

  assign oh_o = 16'd1 << sel_i;

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search sequencer: FSM, 13-bit cycle counter and output decode.
// Optional abort input enabled by ME_SEARCH_CTRL_ABORT_EN.
module me_search_ctrl
  import me_pkg::*;
(
  input logic              i_clk,
  input logic              i_rst_n,
  me_search_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);
  localparam logic [1:0] S_HOLD = 2'(ST_HOLD);

  logic [1:0]  state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic        abort;

`ifdef ME_SEARCH_CTRL_ABORT_EN
  assign abort = bus.i_abort;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (bus.i_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 13'(LAST_CNT)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      S_DONE: begin
        state_d = abort ? S_IDLE : S_HOLD;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic              run, lo, head;
  logic [15:0]       oh;
  logic [3:0]        r_fin;
  logic [4:0]        row;
  logic signed [5:0] vx6, vy6;
  logic [15:0]       mux;

  assign run  = (state_q == S_RUN);
  assign lo   = ~cnt_q[12];
  assign head = (cnt_q[7:4] == 4'd0);

  me_onehot16 u_oh (
    .sel_i (cnt_q[3:0]),
    .oh_o  (oh)
  );

  // Pass finishing now started one row pass (256 cycles) earlier.
  assign r_fin = 4'(cnt_q[12:8] - 5'd1);
  assign vx6   = $signed({2'b00, cnt_q[3:0]}) - 6'sd8;
  assign vy6   = $signed({2'b00, r_fin}) - 6'sd8;
  assign row   = {1'b0, cnt_q[11:8]} + {1'b0, cnt_q[7:4]};

  always_comb begin
    mux = '0;
    for (int i = 0; i < NUM_PE; i++)
      mux[i] = run & lo & (cnt_q[3:0] < 4'(i));
  end

  logic pe_act;
  assign pe_act = run & (|cnt_q[12:8]) & head;

  assign bus.o_busy      = (state_q == S_RUN) | (state_q == S_DONE);
  assign bus.o_done      = (state_q == S_DONE);
  assign bus.o_CompStart = (run & (cnt_q != '0)) | (state_q == S_DONE)
                         | (state_q == S_HOLD);
  assign bus.o_NewDist   = (run & lo & head) ? oh : '0;
  assign bus.o_PEready   = pe_act ? oh : '0;
  assign bus.o_vectorX   = pe_act ? VEC_W'(vx6) : '0;
  assign bus.o_vectorY   = pe_act ? VEC_W'(vy6) : '0;
  assign bus.o_AddressR  = (run & lo) ? cnt_q[7:0] : '0;
  assign bus.o_AddressS  = (run & lo) ? {row, cnt_q[3:0]} : '0;
  assign bus.o_S1S2mux   = mux;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: directed plan points plus random start/reset
// (and abort) stimulus against a pass/PE-level reference model.
module tb_me_search_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  me_search_ctrl_if bus_if ();

  me_search_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_HOLD = 3;
  int m_ph = M_IDLE;
  int m_mc = 0;
  bit en = 1'b0;
  logic abort_v;

`ifdef ME_SEARCH_CTRL_ABORT_EN
  assign abort_v = bus_if.i_abort;
`else
  assign abort_v = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = M_IDLE; m_mc = 0;
    end else begin
      case (m_ph)
        M_IDLE, M_HOLD:
          if (bus_if.i_start) begin m_ph = M_RUN; m_mc = 0; end
        M_RUN:
          if (abort_v) begin m_ph = M_IDLE; m_mc = 0; end
          else if (m_mc == 4111) m_ph = M_DONE;
          else m_mc++;
        default:
          m_ph = abort_v ? M_IDLE : M_HOLD;
      endcase
    end
  end

  int seen [16][16];
  int pulses;

  task automatic sb_clear();
    pulses = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) seen[a][b] = 0;
  endtask

  task automatic sb_check();
    int cov, dup;
    cov = 0; dup = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        if (seen[a][b] > 0) cov++;
        if (seen[a][b] > 1) dup++;
      end
    chk("sb_pulses", pulses, 256);
    chk("sb_cover", cov, 256);
    chk("sb_dup", dup, 0);
  endtask

  always @(negedge clk) begin
    if (en) begin
      logic [15:0] e_nd, e_pr, e_mx;
      logic [7:0]  e_vx, e_vy, e_ar;
      logic [8:0]  e_as;
      int p, k, ix, iy;
      e_nd = '0; e_pr = '0; e_mx = '0;
      e_vx = '0; e_vy = '0; e_ar = '0; e_as = '0;
      if (m_ph == M_RUN) begin
        if (m_mc < 4096) begin
          p = m_mc % 256;
          if (p < 16) e_nd = 16'(1 << p);
          e_ar = 8'(p);
          e_as = 9'((m_mc / 256 + p / 16) * 16 + m_mc % 16);
          for (int i = 0; i < 16; i++)
            if (m_mc % 16 < i) e_mx[i] = 1'b1;
        end
        if (m_mc >= 256) begin
          k = m_mc - 256;
          if (k % 256 < 16) begin
            e_pr = 16'(1 << (k % 256));
            e_vx = 8'(k % 256 - 8);
            e_vy = 8'(k / 256 - 8);
          end
        end
      end
      chk("busy", bus_if.o_busy, (m_ph == M_RUN || m_ph == M_DONE));
      chk("done", bus_if.o_done, (m_ph == M_DONE));
      chk("compstart", bus_if.o_CompStart,
          (m_ph == M_RUN && m_mc != 0) || m_ph == M_DONE || m_ph == M_HOLD);
      chk("newdist", bus_if.o_NewDist, e_nd);
      chk("peready", bus_if.o_PEready, e_pr);
      chk("vecx", bus_if.o_vectorX, e_vx);
      chk("vecy", bus_if.o_vectorY, e_vy);
      chk("addrR", bus_if.o_AddressR, e_ar);
      chk("addrS", bus_if.o_AddressS, e_as);
      chk("s1s2", bus_if.o_S1S2mux, e_mx);
      if (m_ph == M_RUN) begin
        case (m_mc)
          0:    begin chk("c0_cs", bus_if.o_CompStart, 0);
                      chk("c0_nd", bus_if.o_NewDist, 16'h0001); end
          1:    chk("c1_cs", bus_if.o_CompStart, 1);
          3:    chk("c3_mux", bus_if.o_S1S2mux, 16'hFFF0);
          256:  begin chk("c256_pr", bus_if.o_PEready, 16'h0001);
                      chk("c256_x", bus_if.o_vectorX, 8'hF8);
                      chk("c256_y", bus_if.o_vectorY, 8'hF8); end
          271:  begin chk("c271_pr", bus_if.o_PEready, 16'h8000);
                      chk("c271_x", bus_if.o_vectorX, 8'h07);
                      chk("c271_y", bus_if.o_vectorY, 8'hF8); end
          272:  chk("c272_pr", bus_if.o_PEready, 0);
          300:  begin chk("c300_ar", bus_if.o_AddressR, 44);
                      chk("c300_as", bus_if.o_AddressS, 60); end
          3855: chk("c3855_nd", bus_if.o_NewDist, 16'h8000);
          4100: begin chk("c4100_ar", bus_if.o_AddressR, 0);
                      chk("c4100_as", bus_if.o_AddressS, 0);
                      chk("c4100_mux", bus_if.o_S1S2mux, 0); end
          4111: begin chk("c4111_pr", bus_if.o_PEready, 16'h8000);
                      chk("c4111_x", bus_if.o_vectorX, 8'h07);
                      chk("c4111_y", bus_if.o_vectorY, 8'h07); end
          default: ;
        endcase
        if (m_mc == 0) sb_clear();
        if (bus_if.o_PEready != 0) begin
          ix = $signed(bus_if.o_vectorX) + 8;
          iy = $signed(bus_if.o_vectorY) + 8;
          if (ix >= 0 && ix < 16 && iy >= 0 && iy < 16) seen[ix][iy]++;
          pulses += $countones(bus_if.o_PEready);
        end
      end
      if (m_ph == M_DONE) sb_check();
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_c(int target);
    int k;
    for (k = 0; k < 6000 && !(m_ph == M_RUN && m_mc == target); k++)
      @(negedge clk);
    chk("wait_bound", (k < 6000), 1);
  endtask

  task automatic set_abort(logic v);
`ifdef ME_SEARCH_CTRL_ABORT_EN
    bus_if.i_abort = v;
`else
    if (v) $display("abort not built in");
`endif
  endtask

  int busy_n;

  initial begin
    rst_n = 1'b0;
    bus_if.i_start = 1'b0;
    set_abort(1'b0);
    sb_clear();
    @(negedge clk);
    en = 1'b1;
    cyc(1);
    chk("rst_busy", bus_if.o_busy, 0);
    chk("rst_cs", bus_if.o_CompStart, 0);
    rst_n = 1'b1;
    cyc(2);

    bus_if.i_start = 1'b1; cyc(1); bus_if.i_start = 1'b0;
    wait_c(1000);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    chk("midrst_busy", bus_if.o_busy, 0);
    chk("midrst_done", bus_if.o_done, 0);
    cyc(3);

    bus_if.i_start = 1'b1; cyc(1); bus_if.i_start = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 5000 && !bus_if.o_done; k++) begin
      if (bus_if.o_busy) busy_n++;
      cyc(1);
    end
    chk("run_len", busy_n, 4112);
    chk("done_pulse", bus_if.o_done, 1);
    cyc(1);
    chk("hold_done", bus_if.o_done, 0);
    chk("hold_cs", bus_if.o_CompStart, 1);
    chk("hold_busy", bus_if.o_busy, 0);
    cyc(3);

    bus_if.i_start = 1'b1;
    cyc(2 * 4114 + 4);
    bus_if.i_start = 1'b0;
    cyc(10);

`ifdef ME_SEARCH_CTRL_ABORT_EN
    bus_if.i_start = 1'b1;
    wait_c(500);
    set_abort(1'b1); cyc(1); set_abort(1'b0);
    chk("abort_busy", bus_if.o_busy, 0);
    chk("abort_done", bus_if.o_done, 0);
    bus_if.i_start = 1'b0;
    cyc(3);
`endif

    for (int k = 0; k < 9000; k++) begin
      bus_if.i_start = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 2999) != 0);
`ifdef ME_SEARCH_CTRL_ABORT_EN
      set_abort($urandom_range(0, 1999) == 0);
`endif
      cyc(1);
    end
    rst_n = 1'b1;
    bus_if.i_start = 1'b0;
    set_abort(1'b0);
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
